// File: rtl/toast_lsu_pkg.sv
// toast_lsu shared definitions: memory op encodings,
// response cause codes and LSU FSM state encoding.
package toast_lsu_pkg;

  localparam logic [3:0] MEM_LB   = 4'b0000;
  localparam logic [3:0] MEM_LH   = 4'b0001;
  localparam logic [3:0] MEM_LW   = 4'b0010;
  localparam logic [3:0] MEM_LB_U = 4'b0100;
  localparam logic [3:0] MEM_LH_U = 4'b0101;
  localparam logic [3:0] MEM_SB   = 4'b1000;
  localparam logic [3:0] MEM_SH   = 4'b1001;
  localparam logic [3:0] MEM_SW   = 4'b1010;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_BUS_ERR = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ0  = 3'd1,
    ST_WAIT0 = 3'd2,
    ST_REQ1  = 3'd3,
    ST_WAIT1 = 3'd4,
    ST_RESP  = 3'd5
  } state_t;

  function automatic logic op_is_store(
    input logic [3:0] op
  );
    return op[3];
  endfunction

endpackage

// File: rtl/toast_lsu_align.sv
// toast_lsu byte-lane steering for stores and
// load extraction/extension across up to two words.
module toast_lsu_align
  import toast_lsu_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_lo_i,
  input  logic [23:0] rdata_hi_i,
  output logic [3:0]  be_lo_o,
  output logic [3:0]  be_hi_o,
  output logic [31:0] wdata_lo_o,
  output logic [31:0] wdata_hi_o,
  output logic        misaligned_o,
  output logic [31:0] load_o
);

  logic        is_b;
  logic        is_h;
  logic        uns;
  logic [3:0]  be_base;
  logic [31:0] wmask;
  logic [7:0]  be_wide;
  logic [63:0] wd_wide;
  logic [31:0] word;

  assign is_b = (op_i[1:0] == 2'b00);
  assign is_h = (op_i[1:0] == 2'b01);
  assign uns  = op_i[2];

  // Base lane mask and store data trimmed to size.
  always_comb begin
    be_base = 4'b1111;
    wmask   = wdata_i;
    unique case (1'b1)
      is_b: begin
        be_base = 4'b0001;
        wmask   = {24'b0, wdata_i[7:0]};
      end
      is_h: begin
        be_base = 4'b0011;
        wmask   = {16'b0, wdata_i[15:0]};
      end
      default: ;
    endcase
  end

  assign be_wide = {4'b0, be_base} << off_i;
  assign wd_wide = {32'b0, wmask} << {off_i, 3'b000};

  assign be_lo_o      = be_wide[3:0];
  assign be_hi_o      = be_wide[7:4];
  assign wdata_lo_o   = wd_wide[31:0];
  assign wdata_hi_o   = wd_wide[63:32];
  assign misaligned_o = |be_wide[7:4];

  // Shift the two-word window down to the addressed byte.
  always_comb begin
    word = rdata_lo_i;
    unique case (off_i)
      2'd0: word = rdata_lo_i;
      2'd1: word = {rdata_hi_i[7:0], rdata_lo_i[31:8]};
      2'd2: word = {rdata_hi_i[15:0], rdata_lo_i[31:16]};
      default: word = {rdata_hi_i[23:0], rdata_lo_i[31:24]};
    endcase
  end

  // Sign/zero extension; stores return zero.
  always_comb begin
    load_o = word;
    if (op_is_store(op_i)) begin
      load_o = '0;
    end else if (is_b) begin
      load_o = {{24{~uns & word[7]}}, word[7:0]};
    end else if (is_h) begin
      load_o = {{16{~uns & word[15]}}, word[15:0]};
    end
  end

endmodule

// File: rtl/toast_lsu.sv
// toast_lsu load/store unit, one access outstanding.
// Define TOAST_LSU_MISALIGNED_EN to split misaligned ops.
module toast_lsu
  import toast_lsu_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [3:0]        req_op_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [4:0]        req_rd_addr_i,
  output logic              bus_req_o,
  input  logic              bus_gnt_i,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_be_o,
  output logic [31:0]       bus_wdata_o,
  input  logic              bus_rvalid_i,
  input  logic [31:0]       bus_rdata_i,
  input  logic              bus_err_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic [4:0]        rsp_rd_addr_o,
  output logic              rsp_exception_o,
  output logic [1:0]        rsp_cause_o,
  output logic              busy_o
);

`ifdef TOAST_LSU_MISALIGNED_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  localparam int TLIM =
    (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam int CW =
    (TLIM > 0) ? $clog2(TLIM + 1) : 1;

  state_t state_q;
  state_t state_d;

  logic [3:0]        op_q;
  logic [1:0]        off_q;
  logic [4:0]        rd_q;
  logic              split_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [3:0]        be_hi_q;
  logic [31:0]       wd_q;
  logic [31:0]       wd_hi_q;
  logic [31:0]       rdata_lo_q;
  logic [CW-1:0]     cnt_q;
  logic [31:0]       rsp_rdata_q;
  logic [4:0]        rsp_rd_q;
  logic              rsp_exc_q;
  logic [1:0]        rsp_cause_q;

  logic        idle;
  logic        in_wait;
  logic        tmo;
  logic        misal;
  logic        mis_fault;
  logic        wait_to_resp;
  logic [3:0]  a_op;
  logic [1:0]  a_off;
  logic [31:0] a_lo;
  logic [3:0]  be_lo;
  logic [3:0]  be_hi;
  logic [31:0] wd_lo;
  logic [31:0] wd_hi;
  logic [31:0] load_data;

  assign idle    = (state_q == ST_IDLE);
  assign in_wait = (state_q == ST_WAIT0) ||
                   (state_q == ST_WAIT1);
  assign tmo     = (TIMEOUT_CYCLES > 0) &&
                   (cnt_q == CW'(TLIM));

  assign a_op  = idle ? req_op_i : op_q;
  assign a_off = idle ? req_addr_i[1:0] : off_q;
  assign a_lo  = (state_q == ST_WAIT0) ?
                 bus_rdata_i : rdata_lo_q;

  toast_lsu_align u_align (
    .op_i         (a_op),
    .off_i        (a_off),
    .wdata_i      (req_wdata_i),
    .rdata_lo_i   (a_lo),
    .rdata_hi_i   (bus_rdata_i[23:0]),
    .be_lo_o      (be_lo),
    .be_hi_o      (be_hi),
    .wdata_lo_o   (wd_lo),
    .wdata_hi_o   (wd_hi),
    .misaligned_o (misal),
    .load_o       (load_data)
  );

  assign mis_fault    = misal && !SPLIT_EN;
  assign wait_to_resp = in_wait &&
                        (state_d == ST_RESP);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state; bus error and data take priority over timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i)
          state_d = mis_fault ? ST_RESP : ST_REQ0;
      end
      ST_REQ0: begin
        if (bus_gnt_i) state_d = ST_WAIT0;
      end
      ST_WAIT0: begin
        if (bus_rvalid_i)
          state_d = (!bus_err_i && split_q) ?
                    ST_REQ1 : ST_RESP;
        else if (tmo)
          state_d = ST_RESP;
      end
      ST_REQ1: begin
        if (bus_gnt_i) state_d = ST_WAIT1;
      end
      ST_WAIT1: begin
        if (bus_rvalid_i || tmo) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch, bus beat registers and response capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q        <= '0;
      off_q       <= '0;
      rd_q        <= '0;
      split_q     <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      be_hi_q     <= '0;
      wd_q        <= '0;
      wd_hi_q     <= '0;
      rdata_lo_q  <= '0;
      cnt_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_rd_q    <= '0;
      rsp_exc_q   <= 1'b0;
      rsp_cause_q <= CAUSE_NONE;
    end else begin
      if (idle && req_valid_i) begin
        op_q    <= req_op_i;
        off_q   <= req_addr_i[1:0];
        rd_q    <= req_rd_addr_i;
        split_q <= misal && SPLIT_EN;
        be_hi_q <= be_hi;
        wd_hi_q <= wd_hi;
        if (mis_fault) begin
          rsp_rdata_q <= '0;
          rsp_rd_q    <= req_rd_addr_i;
          rsp_exc_q   <= 1'b1;
          rsp_cause_q <= CAUSE_MISALIGN;
        end else begin
          addr_q <= {req_addr_i[ADDR_W-1:2], 2'b00};
          we_q   <= op_is_store(req_op_i);
          be_q   <= be_lo;
          wd_q   <= wd_lo;
        end
      end
      if (bus_req_o && bus_gnt_i)
        cnt_q <= '0;
      else if (in_wait && !bus_rvalid_i)
        cnt_q <= cnt_q + CW'(1);
      if (state_q == ST_WAIT0 && state_d == ST_REQ1) begin
        rdata_lo_q <= bus_rdata_i;
        addr_q     <= addr_q + ADDR_W'(4);
        be_q       <= be_hi_q;
        wd_q       <= wd_hi_q;
      end
      if (wait_to_resp) begin
        rsp_rd_q <= rd_q;
        if (bus_rvalid_i && bus_err_i) begin
          rsp_rdata_q <= '0;
          rsp_exc_q   <= 1'b1;
          rsp_cause_q <= CAUSE_BUS_ERR;
        end else if (bus_rvalid_i) begin
          rsp_rdata_q <= load_data;
          rsp_exc_q   <= 1'b0;
          rsp_cause_q <= CAUSE_NONE;
        end else begin
          rsp_rdata_q <= '0;
          rsp_exc_q   <= 1'b1;
          rsp_cause_q <= CAUSE_TIMEOUT;
        end
      end
    end
  end

  assign req_ready_o     = idle;
  assign busy_o          = !idle;
  assign bus_req_o       = (state_q == ST_REQ0) ||
                           (state_q == ST_REQ1);
  assign bus_addr_o      = addr_q;
  assign bus_we_o        = we_q;
  assign bus_be_o        = be_q;
  assign bus_wdata_o     = wd_q;
  assign rsp_valid_o     = (state_q == ST_RESP);
  assign rsp_rdata_o     = rsp_rdata_q;
  assign rsp_rd_addr_o   = rsp_rd_q;
  assign rsp_exception_o = rsp_exc_q;
  assign rsp_cause_o     = rsp_cause_q;

endmodule

// File: doc/toast_lsu.md
TOAST_LSU -- requirements
Module: toast_lsu

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64: bus response timeout in cycles; 0 disables the timeout.
REQ-003 SHALL have ports in this order:
- clk_i  in  1  sole clock, rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- req_valid_i  in  1  EX request valid.
- req_ready_o  out  1  LSU accepts a request.
- req_op_i  in  4  memory op, shared MEM_* encoding (LB/LH/LW/LB_U/LH_U/SB/SH/SW).
- req_addr_i  in  ADDR_W  byte address.
- req_wdata_i  in  32  store data.
- req_rd_addr_i  in  5  destination register, returned with the response.
- bus_req_o  out  1  bus request.
- bus_gnt_i  in  1  bus grant.
- bus_addr_o  out  ADDR_W  word-aligned address; bits [1:0]=0.
- bus_we_o  out  1  write.
- bus_be_o  out  4  byte enables.
- bus_wdata_o  out  32  lane-aligned write data.
- bus_rvalid_i  in  1  response valid (read data or write ack).
- bus_rdata_i  in  32  read data.
- bus_err_i  in  1  error, qualified by bus_rvalid_i.
- rsp_valid_o  out  1  one-cycle response pulse.
- rsp_rdata_o  out  32  extended load data; 0 for stores.
- rsp_rd_addr_o  out  5  copy of req_rd_addr_i.
- rsp_exception_o  out  1  response carries a fault.
- rsp_cause_o  out  2  00 none, 01 misaligned, 10 bus error, 11 timeout.
- busy_o  out  1  high in any state except IDLE; feeds pipeline stall logic.

Function
REQ-004 SHALL use FSM states IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP, with one transaction outstanding at most.
REQ-005 req_ready_o SHALL be high only in IDLE; req_valid_i&&req_ready_o latches op, address, data and rd, then goes to REQ0.
REQ-006 In REQ0/REQ1, bus_req_o=1, and address, we, be and wdata SHALL stay registered and stable until bus_gnt_i is high, then go to WAIT0/WAIT1.
REQ-007 In WAIT states, bus_rvalid_i SHALL be accepted no earlier than the cycle after the grant; bus_rvalid_i in IDLE, REQ or RESP SHALL be ignored.
REQ-008 A single-word access SHALL go WAIT0->RESP on rvalid; a split access SHALL go WAIT0->REQ1->WAIT1->RESP.
REQ-009 RESP SHALL last one cycle, drive rsp_valid_o=1, then return to IDLE.
REQ-010 Minimum latency SHALL be: accept in cycle N, grant in N+1, rvalid in N+2, rsp_valid_o in N+3.
REQ-011 Byte lanes SHALL be selected by addr[1:0].
- SB/LB: lane = addr[1:0].
- SH/LH: lanes addr[1:0] and addr[1:0]+1.
- SW/LW: all four lanes.
- Stores: unused lanes of bus_wdata_o are 0.
REQ-012 Loads SHALL assemble little-endian bytes.
- LB/LH: sign-extend.
- LB_U/LH_U: zero-extend.
- LW: no extension.
REQ-013 Access is misaligned when byte lanes cross a word boundary (LH/SH at offset 3; LW/SW at offsets 1-3).
REQ-014 bus_rvalid_i&&bus_err_i in any WAIT state SHALL abort the access, go to RESP with cause 10, and issue no second access; a half-completed split store is not rolled back.
REQ-015 With TIMEOUT_CYCLES>0, a counter cleared on each grant SHALL count WAIT cycles; reaching TIMEOUT_CYCLES SHALL go to RESP with cause 11.
REQ-016 If a fault and a response arrive in the same cycle, bus error SHALL win over timeout.

Reset
REQ-017 rst_i sampled high SHALL force IDLE on the next edge, from any state, including mid split access.
REQ-018 After reset, all outputs SHALL be 0 (bus_addr_o, bus_wdata_o, rsp_rdata_o and rsp_rd_addr_o included), except req_ready_o=1.

Configuration
REQ-019 With macro TOAST_LSU_MISALIGNED_EN defined, misaligned accesses SHALL be split into two bus accesses:
- first access at addr&~3, upper lanes.
- second access at (addr&~3)+4, remaining low lanes.
- load data merged before extension.
REQ-020 Without TOAST_LSU_MISALIGNED_EN, a misaligned request SHALL issue no bus access and go IDLE->RESP with cause 01 (response in cycle N+1); REQ1/WAIT1 are unreachable and may be omitted.

Structure
REQ-021 Package toast_lsu_pkg SHALL hold:
- MEM_* op encodings, shared with the existing definitions.
- cause code constants.
- FSM state encoding.
REQ-022 Byte-lane steering, load extraction and extension SHALL live in one combinational sub-module, toast_lsu_align.

Verification
REQ-023 SW addr 0x1000, data 0xDEADBEEF, gnt in N+1, rvalid in N+2 -> bus_be_o=1111, bus_wdata_o=0xDEADBEEF, rsp_valid_o in N+3, cause 00.
REQ-024 LB at 0x2002, rdata 0x00800000 -> rsp_rdata_o=0xFFFFFF80; LB_U at the same address -> 0x00000080.
REQ-025 With the macro, LH at 0x1003:
- first access: 0x1000, be 1000, rdata 0xAB000000.
- second access: 0x1004, be 0001, rdata 0x000000CD.
- result: rsp_rdata_o=0xFFFFCDAB; without the macro, no bus_req_o and cause 01.
REQ-026 TIMEOUT_CYCLES=16, grant given, no rvalid -> rsp_valid_o with cause 11 sixteen WAIT cycles after the grant; a late rvalid afterwards is ignored.
REQ-027 rst_i asserted in WAIT1 -> next cycle bus_req_o=0, rsp_valid_o=0, req_ready_o=1; a stray rvalid then produces no response.
